// File: rtl/conv_axis_out.sv
// AXI-stream output stage for fixed-latency convolution cores: tracks beat validity
// through the core pipeline, throttles it by FIFO credit, and emits frame-delimited beats.
module conv_axis_out #(
  parameter int WORD_WIDTH      = 128,
  parameter int CORE_LATENCY    = 9,
  parameter int FIFO_DEPTH      = 16,
  parameter int BEATS_PER_FRAME = 16384
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  core_en,
  input  logic [WORD_WIDTH-1:0] core_tdata,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  frame_done
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PCNT_W  = $clog2(CORE_LATENCY + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int FRAME_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam logic [FRAME_W-1:0] LAST_BEAT = FRAME_W'(BEATS_PER_FRAME - 1);

  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;

  function automatic logic [PCNT_W-1:0] popcount(input logic [CORE_LATENCY-1:0] v);
    logic [PCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < CORE_LATENCY; i++) begin
      c = c + PCNT_W'(v[i]);
    end
    return c;
  endfunction

  state_t                  state_q, state_d;
  logic [CORE_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [WORD_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [FRAME_W-1:0]      in_cnt_q, in_cnt_d;
  logic [FRAME_W-1:0]      out_cnt_q, out_cnt_d;
  logic                    frame_done_q;
  logic [SUM_W-1:0]        occupancy_s;
  logic                    in_hs_s, push_s, pop_s;

  // Pipe plus FIFO occupancy is the credit: a beat may enter only if a slot is reserved for it.
  assign occupancy_s   = SUM_W'(fifo_cnt_q) + SUM_W'(popcount(vpipe_q));
  assign core_en       = s_axis_aresetn & (occupancy_s < SUM_W'(FIFO_DEPTH));
  assign push_s        = core_en & vpipe_q[CORE_LATENCY-1];
  assign m_axis_tvalid = (fifo_cnt_q != CNT_W'(0));
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign m_axis_tlast  = m_axis_tvalid & (out_cnt_q == LAST_BEAT);
  assign pop_s         = m_axis_tvalid & m_axis_tready;
  assign frame_done    = frame_done_q;

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    s_axis_tready = 1'b0;
    in_hs_s       = 1'b0;
    case (state_q)
      FILL: begin
        s_axis_tready = core_en;
        in_hs_s       = s_axis_tvalid & core_en;
        if (in_hs_s) begin
          if (in_cnt_q == LAST_BEAT) begin
            in_cnt_d = '0;
            state_d  = FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + FRAME_W'(1);
          end
        end else begin
          in_cnt_d = in_cnt_q;
        end
      end
      FLUSH: begin
        if (pop_s && m_axis_tlast) begin
          state_d = FILL;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = in_hs_s;
    for (int i = 1; i < CORE_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    out_cnt_d = out_cnt_q;
    if (pop_s) begin
      out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + FRAME_W'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= FILL;
      vpipe_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      fifo_cnt_q   <= fifo_cnt_d;
      frame_done_q <= pop_s & m_axis_tlast;
      if (core_en) begin
        vpipe_q <= vpipe_d;
      end
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only visible once fifo_cnt counts it.
  always_ff @(posedge s_axis_aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= core_tdata;
    end
  end

endmodule
